// File: rtl/sd_stream_pkg.sv
// Shared definitions for the SD audio streamer: sector size and controller FSM encoding.
package sd_stream_pkg;

    localparam int unsigned SECTOR_BYTES = 512;

    typedef enum logic [2:0] {
        StIdle,
        StWaitSpace,
        StWaitReady,
        StRead,
        StDone
    } stream_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO with flush and occupancy count; simultaneous push and pop keep the count steady.
module byte_fifo #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [7:0]               i_din,
    input  logic                     i_pop,
    output logic [7:0]               o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; stale contents are unreachable once pointers are cleared.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/sd_audio_streamer.sv
// Streams SD sectors through a byte FIFO and assembles little-endian audio frames.
// Define STREAMER_LOOP_EN to wrap from END_ADR back to START_ADR instead of finishing.
module sd_audio_streamer
    import sd_stream_pkg::*;
#(
    parameter int unsigned SAMPLE_BYTES = 1,
    parameter int unsigned CHANNELS     = 1,
    parameter int unsigned FIFO_DEPTH   = 1024,
    parameter int unsigned START_ADR    = 0,
    parameter int unsigned END_ADR      = 32'h0010_0000
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_start,
    input  logic                                i_stop,
    input  logic                                i_sd_ready,
    input  logic                                i_sd_byte_available,
    input  logic [7:0]                          i_sd_dout,
    output logic                                o_sd_rd,
    output logic [31:0]                         o_sd_adr,
    output logic [8*SAMPLE_BYTES*CHANNELS-1:0]  o_frame_out,
    output logic                                o_frame_valid,
    input  logic                                i_frame_ready,
    output logic                                o_busy,
    output logic                                o_done,
    output logic [$clog2(FIFO_DEPTH):0]         o_fill
);

    localparam int unsigned FRAME_BYTES = SAMPLE_BYTES * CHANNELS;
    localparam int unsigned FRAME_W     = 8 * FRAME_BYTES;
    localparam int unsigned FILL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W       = $clog2(FRAME_BYTES + 1);
    localparam int unsigned SEC_W       = $clog2(SECTOR_BYTES);
    localparam logic [FILL_W-1:0] SPACE_LIMIT = FILL_W'(FIFO_DEPTH - SECTOR_BYTES);
    localparam logic [SEC_W-1:0]  LAST_BYTE   = SEC_W'(SECTOR_BYTES - 1);
`ifdef STREAMER_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    stream_state_e      r_state;
    logic               r_sd_rd;
    logic [31:0]        r_sd_adr;
    logic [SEC_W-1:0]   r_byte_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_stop_seen;
    logic [FRAME_W-1:0] r_asm;
    logic [CNT_W-1:0]   r_asm_cnt;
    logic [FRAME_W-1:0] r_frame_out;
    logic               r_frame_valid;

    logic               w_flush;
    logic               w_push;
    logic               w_pop;
    logic [7:0]         w_fifo_dout;
    logic [FILL_W-1:0]  w_fill;
    logic               w_fifo_empty;
    logic               w_fifo_full;
    logic [31:0]        w_next_adr;
    logic               w_at_end;
    logic [31:0]        w_adv_adr;
    logic               w_asm_full;
    logic               w_xfer;
    logic [CNT_W-1:0]   w_pos;
    logic               w_drop;

    assign w_flush    = i_start && (r_state == StIdle || r_state == StDone);
    assign w_push     = (r_state == StRead) && i_sd_byte_available && !w_fifo_full;
    assign w_next_adr = r_sd_adr + 32'(SECTOR_BYTES);
    assign w_at_end   = (w_next_adr == 32'(END_ADR));
    assign w_adv_adr  = (LOOP_EN && w_at_end) ? 32'(START_ADR) : w_next_adr;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_din   (i_sd_dout),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_count (w_fill),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_sd_rd     <= 1'b0;
            r_sd_adr    <= 32'(START_ADR);
            r_byte_cnt  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_stop_seen <= 1'b0;
        end else begin
            r_sd_rd <= 1'b0;
            unique case (r_state)
                StIdle, StDone: begin
                    if (i_start) begin
                        r_sd_adr    <= 32'(START_ADR);
                        r_state     <= StWaitSpace;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_stop_seen <= 1'b0;
                    end
                end
                StWaitSpace, StWaitReady: begin
                    // No sector in flight here, so a stop can finish immediately.
                    if (r_stop_seen || i_stop) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_state == StWaitSpace) begin
                        if (w_fill <= SPACE_LIMIT) r_state <= StWaitReady;
                    end else if (i_sd_ready) begin
                        r_sd_rd    <= 1'b1;
                        r_byte_cnt <= '0;
                        r_state    <= StRead;
                    end
                end
                StRead: begin
                    if (i_stop) r_stop_seen <= 1'b1;
                    if (i_sd_byte_available) begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (r_byte_cnt == LAST_BYTE) begin
                            r_sd_adr <= w_adv_adr;
                            if (r_stop_seen || i_stop || (w_at_end && !LOOP_EN)) begin
                                r_state <= StDone;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= StWaitSpace;
                            end
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Assembler holds one frame in progress; the output register holds the presented frame.
    assign w_asm_full = (r_asm_cnt == CNT_W'(FRAME_BYTES));
    assign w_xfer     = w_asm_full && (!r_frame_valid || i_frame_ready);
    assign w_pop      = !w_fifo_empty && (!w_asm_full || w_xfer);
    assign w_pos      = w_xfer ? '0 : r_asm_cnt;
    assign w_drop     = (r_state == StDone) && w_fifo_empty && !w_asm_full && (r_asm_cnt != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_asm         <= '0;
            r_asm_cnt     <= '0;
            r_frame_out   <= '0;
            r_frame_valid <= 1'b0;
        end else if (w_flush) begin
            r_asm_cnt     <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_frame_out   <= r_asm;
                r_frame_valid <= 1'b1;
            end else if (i_frame_ready) begin
                r_frame_valid <= 1'b0;
            end
            for (int b = 0; b < FRAME_BYTES; b++) begin
                if (w_pop && w_pos == CNT_W'(b)) r_asm[8*b +: 8] <= w_fifo_dout;
            end
            if (w_xfer)      r_asm_cnt <= w_pop ? CNT_W'(1) : '0;
            else if (w_pop)  r_asm_cnt <= r_asm_cnt + 1'b1;
            else if (w_drop) r_asm_cnt <= '0;
        end
    end

    assign o_sd_rd       = r_sd_rd;
    assign o_sd_adr      = r_sd_adr;
    assign o_frame_out   = r_frame_out;
    assign o_frame_valid = r_frame_valid;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_fill        = w_fill;

endmodule

// File: tb/tb_sd_audio_streamer.sv
// Directed bench for sd_audio_streamer: 1-byte mono stream against an SD byte model,
// plus a 2-byte stereo instance driven by hand.
module tb_sd_audio_streamer;

    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0, stop = 1'b0, sd_ready = 1'b0, byte_av, ready;
    logic [7:0]  dout;
    logic        sd_rd, valid, busy, done;
    logic [31:0] sd_adr;
    logic [7:0]  frame;
    logic [10:0] fill;

    logic        start2 = 1'b0, stop2 = 1'b0, sd_ready2 = 1'b1, byte_av2 = 1'b0, ready2 = 1'b0;
    logic [7:0]  dout2 = 8'h00;
    logic        sd_rd2, valid2, busy2, done2;
    logic [31:0] adr2;
    logic [31:0] frame2;
    logic [10:0] fill2;

    sd_audio_streamer #(
        .SAMPLE_BYTES (1),
        .CHANNELS     (1),
        .FIFO_DEPTH   (DEPTH),
        .START_ADR    (0),
        .END_ADR      (1024)
    ) u_dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_start             (start),
        .i_stop              (stop),
        .i_sd_ready          (sd_ready),
        .i_sd_byte_available (byte_av),
        .i_sd_dout           (dout),
        .o_sd_rd             (sd_rd),
        .o_sd_adr            (sd_adr),
        .o_frame_out         (frame),
        .o_frame_valid       (valid),
        .i_frame_ready       (ready),
        .o_busy              (busy),
        .o_done              (done),
        .o_fill              (fill)
    );

    sd_audio_streamer #(
        .SAMPLE_BYTES (2),
        .CHANNELS     (2),
        .FIFO_DEPTH   (DEPTH)
    ) u_dut2 (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_start             (start2),
        .i_stop              (stop2),
        .i_sd_ready          (sd_ready2),
        .i_sd_byte_available (byte_av2),
        .i_sd_dout           (dout2),
        .o_sd_rd             (sd_rd2),
        .o_sd_adr            (adr2),
        .o_frame_out         (frame2),
        .o_frame_valid       (valid2),
        .i_frame_ready       (ready2),
        .o_busy              (busy2),
        .o_done              (done2),
        .o_fill              (fill2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // SD card model: data byte = low 8 bits of (sector address + offset), with periodic gaps.
    int          send_left = 0, send_idx = 0, cyc = 0;
    logic [31:0] send_adr = '0;
    logic        prev_rd = 1'b0;
    int          rd_count = 0, double_rd = 0, rd_fill_bad = 0, max_fill = 0;
    logic [31:0] adr_log[$];
    bit          stray_req = 1'b0;

    initial begin
        byte_av = 1'b0;
        dout    = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                send_left = 0;
                byte_av   = 1'b0;
                prev_rd   = 1'b0;
            end else begin
                if (sd_rd) begin
                    rd_count++;
                    adr_log.push_back(sd_adr);
                    if (fill > 11'(DEPTH - 512)) rd_fill_bad++;
                    if (prev_rd) double_rd++;
                    send_left = 512;
                    send_idx  = 0;
                    send_adr  = sd_adr;
                end
                prev_rd = sd_rd;
                if (int'(fill) > max_fill) max_fill = int'(fill);
                if (stray_req) begin
                    byte_av = 1'b1;
                    dout    = 8'hAA;
                end else if (send_left > 0 && (cyc % 7) != 3) begin
                    byte_av = 1'b1;
                    dout    = 8'(send_adr + 32'(send_idx));
                    send_idx++;
                    send_left--;
                end else begin
                    byte_av = 1'b0;
                end
            end
        end
    end

    // Frame consumer: every accepted frame must continue the 0..255 byte ramp.
    logic [7:0] exp_byte = 8'h00;
    int         frames_rx = 0;
    bit         consume_en = 1'b0;

    initial begin
        ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) exp_byte = 8'h00;
            ready = consume_en;
            if (!rst && valid && ready) begin
                check_eq("frame_data", 32'(frame), 32'(exp_byte));
                exp_byte++;
                frames_rx++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic finish_stream(input string tag, input int base_log, input int base_frames,
                                 input int min_sectors);
        int n;
`ifdef STREAMER_LOOP_EN
        n = 0;
        while (adr_log.size() - base_log < min_sectors && n < 30000) begin
            tick(1);
            n++;
        end
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
`else
        n = min_sectors;
`endif
        n = 0;
        while (!done && n < 30000) begin
            tick(1);
            n++;
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        n = 0;
        while (frames_rx - base_frames < 512 * (adr_log.size() - base_log) && n < 8000) begin
            tick(1);
            n++;
        end
        check_eq({tag, "_frames"}, 32'(frames_rx - base_frames),
                 32'(512 * (adr_log.size() - base_log)));
        check_eq({tag, "_fill"}, 32'(fill), 32'd0);
    endtask

    task automatic feed2(input logic [7:0] b);
        byte_av2 = 1'b1;
        dout2    = b;
        tick(1);
        byte_av2 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b_log, b_frm, b_rd, n;

        // Reset values
        tick(3);
        check_eq("rst_sd_rd", 32'(sd_rd), 32'd0);
        check_eq("rst_sd_adr", sd_adr, 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_frame", 32'(frame), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_fill", 32'(fill), 32'd0);
        rst = 1'b0;
        tick(2);

        // Bytes offered while idle are discarded
        stray_req = 1'b1;
        tick(10);
        stray_req = 1'b0;
        tick(2);
        check_eq("idle_stray_fill", 32'(fill), 32'd0);

        // Long sd_ready=0 wait (with stray bytes), then a full two-sector stream
        consume_en = 1'b1;
        b_log = adr_log.size();
        b_frm = frames_rx;
        b_rd  = rd_count;
        pulse_start();
        stray_req = 1'b1;
        tick(500);
        stray_req = 1'b0;
        check_eq("wait_ready_no_rd", 32'(rd_count - b_rd), 32'd0);
        check_eq("wait_ready_busy", 32'(busy), 32'd1);
        check_eq("wait_ready_stray_fill", 32'(fill), 32'd0);
        tick(1);
        sd_ready = 1'b1;
        finish_stream("stream", b_log, b_frm, 4);
        check_eq("adr_seq0", adr_log[b_log], 32'd0);
        check_eq("adr_seq1", adr_log[b_log + 1], 32'd512);
`ifdef STREAMER_LOOP_EN
        check_eq("loop_sectors_ge4", 32'(adr_log.size() - b_log >= 4), 32'd1);
        check_eq("adr_seq2", adr_log[b_log + 2], 32'd0);
        check_eq("adr_seq3", adr_log[b_log + 3], 32'd512);
`else
        check_eq("stream_sectors", 32'(adr_log.size() - b_log), 32'd2);
        check_eq("stream_frames_total", 32'(frames_rx - b_frm), 32'd1024);
        check_eq("end_adr", sd_adr, 32'd1024);
`endif

        // Backpressure: consumer stalled for 2000 cycles
        consume_en = 1'b0;
        tick(2);
        b_log = adr_log.size();
        b_frm = frames_rx;
        b_rd  = rd_count;
        pulse_start();
        tick(2000);
        check_eq("bp_rd_pulses", 32'(rd_count - b_rd), 32'd2);
        check_eq("bp_fill", 32'(fill), 32'd1022);
        check_eq("bp_max_fill", 32'(max_fill <= int'(DEPTH)), 32'd1);
        check_eq("bp_valid_held", 32'(valid), 32'd1);
        check_eq("bp_frame_held", 32'(frame), 32'h00);
        consume_en = 1'b1;
        finish_stream("bp", b_log, b_frm, 3);

        // Stop during the first sector finishes after that sector
        b_log = adr_log.size();
        b_frm = frames_rx;
        pulse_start();
        n = 0;
        while (adr_log.size() == b_log && n < 100) begin
            tick(1);
            n++;
        end
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        n = 0;
        while (!done && n < 5000) begin
            tick(1);
            n++;
        end
        check_eq("stop_sectors", 32'(adr_log.size() - b_log), 32'd1);
        check_eq("stop_adr", sd_adr, 32'd512);
        finish_stream("stop", b_log, b_frm, 1);

        // Reset in the middle of the second sector
        b_log = adr_log.size();
        pulse_start();
        n = 0;
        while (!(adr_log.size() - b_log >= 2 && send_idx >= 100) && n < 5000) begin
            tick(1);
            n++;
        end
        check_eq("midrst_reached", 32'(adr_log.size() - b_log), 32'd2);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_sd_rd", 32'(sd_rd), 32'd0);
        check_eq("midrst_sd_adr", sd_adr, 32'd0);
        check_eq("midrst_valid", 32'(valid), 32'd0);
        check_eq("midrst_frame", 32'(frame), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_fill", 32'(fill), 32'd0);
        tick(3);
        rst = 1'b0;
        tick(2);
        b_log = adr_log.size();
        b_frm = frames_rx;
        pulse_start();
        finish_stream("restart", b_log, b_frm, 2);
        check_eq("restart_adr0", adr_log[b_log], 32'd0);

        // Stereo 16-bit instance: little-endian frame assembly and hold under backpressure
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        n = 0;
        while (!sd_rd2 && n < 20) begin
            tick(1);
            n++;
        end
        check_eq("s2_sd_rd", 32'(sd_rd2), 32'd1);
        check_eq("s2_adr", adr2, 32'd0);
        check_eq("s2_busy", 32'(busy2), 32'd1);
        feed2(8'h01);
        feed2(8'h02);
        feed2(8'h03);
        feed2(8'h04);
        tick(6);
        check_eq("s2_valid", 32'(valid2), 32'd1);
        check_eq("s2_frame1", frame2, 32'h0403_0201);
        tick(5);
        check_eq("s2_frame1_stable", frame2, 32'h0403_0201);
        feed2(8'h05);
        feed2(8'h06);
        feed2(8'h07);
        feed2(8'h08);
        tick(6);
        check_eq("s2_frame1_held", frame2, 32'h0403_0201);
        check_eq("s2_fill", 32'(fill2), 32'd0);
        check_eq("s2_not_done", 32'(done2), 32'd0);
        ready2 = 1'b1;
        tick(1);
        ready2 = 1'b0;
        check_eq("s2_frame2", frame2, 32'h0807_0605);
        check_eq("s2_valid2", 32'(valid2), 32'd1);

        check_eq("sd_rd_single_cycle", 32'(double_rd), 32'd0);
        check_eq("rd_space_ok", 32'(rd_fill_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
